// File: rtl/regfile_debug_dumper.sv
// ============================================================================
// regfile_debug_dumper
//
// Purpose:
//   Walks the register file's debug read port from address 0 up to
//   NUM_REGS-1 after a start pulse. Each word is captured and presented as an
//   (address, data) pair on a valid/ready stream, for a debug UART or display
//   sink. Peak throughput is one word per cycle. Back-pressure from the sink
//   stalls the walk. An abort cancels the dump and returns to IDLE.
//
// Parameters:
//   WIDTH     data width. Must match the register file data width.
//   NUM_REGS  number of registers dumped (1..32). Addresses 0..NUM_REGS-1.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   one-cycle dump request. Only honoured in IDLE.
//   abort      in   cancels a dump in LOAD/SEND
//   ra_debug   out  register file debug read address (follows the pointer)
//   rd_debug   in   register file debug read data (async read of ra_debug)
//   out_valid  out  out_addr/out_data hold a word
//   out_ready  in   sink accepts the word when out_valid & out_ready
//   out_addr   out  register index of the presented word
//   out_data   out  register value of the presented word
//   busy       out  high while in LOAD or SEND
//   done       out  one-cycle pulse after the last word is accepted
// ============================================================================
module regfile_debug_dumper #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [4:0]       ra_debug,
    input  logic [WIDTH-1:0] rd_debug,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_addr,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    // The pointer has to be able to reach NUM_REGS itself (32 for a full
    // dump). A 5-bit pointer would wrap to 0 there and the end of the walk
    // would look like its start, so it carries one extra bit.
    localparam logic [5:0] END_PTR = 6'(NUM_REGS);

    state_t             state_q, state_d;
    logic [5:0]         ptr_q, ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [4:0]         out_addr_q, out_addr_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // The register file read is asynchronous. The word for the pointer is
    // therefore on rd_debug in the same cycle and is captured directly.
    assign ra_debug = ptr_q[4:0];

    // Next-state logic. Priority: abort > handshake > start. Reset is applied
    // in the register block. An accepted word is replaced in the same cycle
    // when more registers remain, so a ready sink sees no bubbles.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;

        case (state_q)
            ST_IDLE: begin
                ptr_d       = 6'd0;
                out_valid_d = 1'b0;
                if (start) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    ptr_d       = 6'd0;
                    out_valid_d = 1'b0;
                end else begin
                    out_data_d  = rd_debug;
                    out_addr_d  = ptr_q[4:0];
                    out_valid_d = 1'b1;
                    ptr_d       = ptr_q + 6'd1;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND: begin
                if (abort) begin
                    // A word that handshakes in the abort cycle is dropped.
                    state_d     = ST_IDLE;
                    ptr_d       = 6'd0;
                    out_valid_d = 1'b0;
                end else if (out_ready) begin
                    if (ptr_q < END_PTR) begin
                        out_data_d = rd_debug;
                        out_addr_d = ptr_q[4:0];
                        ptr_d      = ptr_q + 6'd1;
                    end else begin
                        out_valid_d = 1'b0;
                        ptr_d       = 6'd0;
                        state_d     = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // start and abort are both ignored here. The pulse always
                // completes, and the block returns to IDLE.
                state_d = ST_IDLE;
            end

            default: begin
                state_d     = ST_IDLE;
                ptr_d       = 6'd0;
                out_valid_d = 1'b0;
            end
        endcase

        // busy and done are registered versions of the next state. They
        // change on the same edge as the state register.
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SEND);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers. A synchronous reset drops any word in
    // flight and does not produce a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 6'd0;
            out_valid_q <= 1'b0;
            out_addr_q  <= 5'd0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
